// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Index width for N requesters, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Producer-side request/data bundle plus the FIFO write port of the arbiter.
interface fifo_write_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4
);
  import fifo_arb_pkg::*;

  localparam int IDX_W = idx_w(N_REQ);

  logic [N_REQ-1:0]            req;
  logic [N_REQ*DATA_WIDTH-1:0] din;
  logic [N_REQ-1:0]            ack;
  logic [DATA_WIDTH-1:0]       fifo_din;
  logic                        fifo_write;
  logic                        fifo_full;
  logic [IDX_W-1:0]            grant_id;
  logic                        busy;

  // Drives requests and FIFO status; observes the arbiter decision.
  modport master (
    output req, din, fifo_full,
    input  ack, fifo_din, fifo_write, grant_id, busy
  );

  // Arbiter side.
  modport slave (
    input  req, din, fifo_full,
    output ack, fifo_din, fifo_write, grant_id, busy
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_select.sv
// Rotating priority encoder: first set request at or after ptr, wrapping mod N_REQ.
module rr_select
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] pos;

  // Scan from the far end so the offset closest to ptr is written last and wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = IDX_W'((int'(ptr) + k) % N_REQ);
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers with bounded bursts.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int BURST      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_write_arbiter_if.slave  bus
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = 4;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic             busy_q, busy_d;

  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] cand;
  logic             cand_req;
  logic             xfer;
  logic             burst_done;
  logic [N_REQ-1:0] ack_v;
  logic [DATA_WIDTH-1:0] word_v;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(N_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  rr_select #(.N_REQ(N_REQ)) u_sel (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  // Write decision is combinational; fifo_full and rst gate it in the same cycle.
  always_comb begin
    cand       = (state_q == LOCK) ? owner_q : sel_idx;
    cand_req   = (state_q == LOCK) ? bus.req[owner_q] : sel_valid;
    xfer       = cand_req && !bus.fifo_full && !rst;
    burst_done = (cnt_q + 4'd1) == CNT_W'(BURST);
  end

  always_comb begin
    ack_v  = '0;
    word_v = '0;
    if (xfer) begin
      ack_v[cand] = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (cand == IDX_W'(i)) word_v = bus.din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.ack        = ack_v;
  assign bus.fifo_din   = word_v;
  assign bus.fifo_write = xfer;
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = busy_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    grant_id_d = grant_id_q;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          grant_id_d = cand;
          if (xfer && BURST == 1) begin
            ptr_d = wrap_inc(cand);
          end else begin
            // A stalled request still takes the grant and keeps it through back-pressure.
            state_d = LOCK;
            owner_d = cand;
            cnt_d   = xfer ? CNT_W'(1) : '0;
          end
        end
      end
      LOCK: begin
        if (!bus.req[owner_q]) begin
          state_d = IDLE;
          ptr_d   = wrap_inc(owner_q);
        end else if (xfer) begin
          grant_id_d = owner_q;
          if (burst_done) begin
            state_d = IDLE;
            ptr_d   = wrap_inc(owner_q);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOCK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the write port of one `fifo_mono` instance among `N_REQ` producer actors in the multi-dataflow fabric. Each producer holds a request with its data word. The arbiter selects one owner and forwards that owner's word into the FIFO. It honours `full` back-pressure and lets an owner keep the port for a bounded burst, so consecutive tokens from one actor stay contiguous.

## Interface
Parameters:
- `DATA_WIDTH`, 8, token width; matches the FIFO.
- `N_REQ`, 4, number of producers; range 2..16.
- `BURST`, 2, maximum consecutive words per grant; range 1..15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-producer request; bit i high means `din` slice i holds a valid word.
- `din`  in  N_REQ*DATA_WIDTH  producer words; slice i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- `ack`  out  N_REQ  one-hot or zero; bit i high means producer i's word is written this cycle.
- `fifo_din`  out  DATA_WIDTH  to FIFO `write_port.din`.
- `fifo_write`  out  1  to FIFO `write_port.write`.
- `fifo_full`  in  1  from FIFO `write_port.full`.
- `grant_id`  out  $clog2(N_REQ)  registered index of the current or last owner.
- `busy`  out  1  registered; high while in LOCK.

## Operation
- States: IDLE (no owner) and LOCK (owner register valid). Registers: `state`, `owner`, `ptr` (round-robin start), `cnt` (words moved in this grant).
- Candidate selection:
  - In IDLE, the candidate is the first i with `req[i]`=1, scanning `ptr`, `ptr+1`, … with wrap mod N_REQ.
  - In LOCK, the candidate is `owner`.
- A transfer occurs when the candidate has `req` high, `fifo_full`=0 and `rst`=0. On a transfer, `fifo_write`=1, `ack[cand]`=1 and `fifo_din`=din slice of the candidate.
- When no transfer occurs, `fifo_write`=0, `ack`=0 and `fifo_din`=0.
- IDLE transitions:
  - No request: stay in IDLE.
  - Transfer and BURST=1: `ptr`←cand+1 (wrapping); stay in IDLE.
  - Transfer and BURST>1: go to LOCK with `owner`←cand, `cnt`←1.
  - Request present but `fifo_full`=1: go to LOCK with `owner`←cand, `cnt`←0. The grant is held through back-pressure.
- LOCK transitions:
  - `req[owner]`=0: release with `ptr`←owner+1; go to IDLE. No transfer happens in the release cycle.
  - Transfer and `cnt+1`==BURST: `ptr`←owner+1; go to IDLE.
  - Transfer and `cnt+1`<BURST: `cnt`←cnt+1; stay in LOCK.
  - `fifo_full`=1: hold all registers.
- `grant_id` is loaded with the candidate on every transfer or LOCK entry. `busy` = (next state == LOCK), registered.
- Producer contract: hold `req` and `din` stable until `ack`. `req` may drop only after `ack`.
- Reset (synchronous, mid-operation included): `state`=IDLE, `ptr`=0, `owner`=0, `cnt`=0, `grant_id`=0, `busy`=0. While `rst` is high, `fifo_write`=0 and `ack`=0. Any burst in progress is abandoned and no partial write is issued.

## Timing
- Zero-cycle latency: `ack`, `fifo_write` and `fifo_din` are combinational from `req`, `fifo_full` and the registers.
- Peak throughput is 1 word/cycle.
- A grant change through a release costs one idle cycle. A change through burst completion costs none.
- `fifo_full` is sampled in the same cycle as the write, so the FIFO never receives a write while full.
- Fairness: with all requesters continuously active, each receives BURST words per N_REQ*BURST cycles, in index order from the reset `ptr`=0.

## Structure
- Package `fifo_arb_pkg`: `arb_state_t` enum {IDLE, LOCK} and the `IDX_W`=$clog2(N_REQ) helper function.
- One sub-module, `rr_select`: combinational rotate-and-priority-encode of `req` from `ptr`, returning `valid` and `idx`.
- Top level instantiates `rr_select` plus the FSM/datapath. The FIFO is not instantiated inside; it connects at the wrapper level.

## Test plan
- Reset then single requester: req=4'b0100, din[2]=8'hA5, BURST=2. Expect ack[2] on 2 consecutive cycles, fifo_din=8'hA5, then return to IDLE with ptr=3.
- All four requesting continuously, FIFO never full, BURST=2. Expect the write order 0,0,1,1,2,2,3,3,0,… with no idle cycles and `grant_id` tracking the owner.
- Back-pressure mid-burst: owner 1 has moved 1 word, then fifo_full=1 for 3 cycles. Expect fifo_write=0, ack=0, busy=1 and owner held at 1. After full clears, expect the second word from producer 1, then a grant change.
- Early release: owner 3 drops req after 1 of BURST=3 words while req[0] is high. Expect one cycle with no write, then ptr=0 and producer 0 acked.
- Wrap-around: ptr=3, req=4'b0011. Expect producer 0 granted first.
- Reset mid-burst: assert rst in LOCK with owner=2, cnt=1. During reset expect fifo_write=0. The next cycle expects state IDLE, busy=0, grant_id=0 and arbitration restarting from index 0.
